// File: rtl/dmem_port_arbiter.sv
// Shares the DMEM read/write port pair between the MEM stage (priority) and a DMA/debug requester.
// Build option: define DMEM_ARB_FAIRNESS_EN for the starvation counter and one-cycle forced DMA grant.
module dmem_port_arbiter #(
   parameter int DMEM_ADDR_WIDTH = 12,
   parameter int DMEM_WORD_WIDTH = 16,
   parameter int STARVE_LIMIT    = 8,
   parameter int CNT_WIDTH       = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cpu_rd_en,
   input  logic                       cpu_wr_en,
   input  logic [DMEM_ADDR_WIDTH-1:0] cpu_rd_addr,
   input  logic [DMEM_ADDR_WIDTH-1:0] cpu_wr_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] cpu_wr_word,
   output logic                       cpu_stall,
   input  logic                       dma_req_valid,
   output logic                       dma_req_ready,
   input  logic                       dma_req_we,
   input  logic [DMEM_ADDR_WIDTH-1:0] dma_req_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] dma_req_wdata,
   output logic                       dma_rsp_valid,
   output logic [DMEM_WORD_WIDTH-1:0] dma_rsp_data,
   output logic [DMEM_ADDR_WIDTH-1:0] dmem_rd_addr,
   output logic [DMEM_ADDR_WIDTH-1:0] dmem_wr_addr,
   output logic [DMEM_WORD_WIDTH-1:0] dmem_wr_word,
   output logic                       dmem_write_en,
   input  logic [DMEM_WORD_WIDTH-1:0] dmem_rd_word
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** CNT_WIDTH) - 1) begin : g_cfg_check
      $error("dmem_port_arbiter: CNT_WIDTH cannot hold STARVE_LIMIT");
   end

   logic                       cpu_act_s;
   logic                       force_s;
   logic                       grant_s;
   logic                       stall_s;
   logic                       rsp_pending_r;
   logic [DMEM_WORD_WIDTH-1:0] rsp_hold_r;

   assign cpu_act_s = cpu_rd_en | cpu_wr_en;

`ifdef DMEM_ARB_FAIRNESS_EN
   logic [CNT_WIDTH-1:0] starve_cnt_r;
   logic                 at_limit_s;

   assign at_limit_s = (starve_cnt_r == CNT_WIDTH'(STARVE_LIMIT));
   assign force_s    = at_limit_s & dma_req_valid;

   // Counts consecutive cycles a waiting DMA request loses to the CPU; saturates at the limit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (grant_s) begin
         starve_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (dma_req_valid & cpu_act_s) begin
         if (at_limit_s) begin
            starve_cnt_r <= starve_cnt_r;
         end else begin
            starve_cnt_r <= starve_cnt_r + CNT_WIDTH'(1);
         end
      end else if (!dma_req_valid) begin
         starve_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end
`else
   assign force_s = 1'b0;
`endif

   assign grant_s       = dma_req_valid & (~cpu_act_s | force_s);
   assign stall_s       = force_s & cpu_act_s;
   assign dma_req_ready = grant_s;
   assign cpu_stall     = stall_s;

   // Port mux: a granted DMA request owns both addresses; otherwise the CPU inputs pass through.
   always_comb begin
      dmem_rd_addr  = cpu_rd_addr;
      dmem_wr_addr  = cpu_wr_addr;
      dmem_wr_word  = cpu_wr_word;
      dmem_write_en = 1'b0;
      if (grant_s) begin
         dmem_rd_addr  = dma_req_addr;
         dmem_wr_addr  = dma_req_addr;
         dmem_wr_word  = dma_req_wdata;
         dmem_write_en = dma_req_we;
      end else begin
         dmem_write_en = cpu_wr_en & ~stall_s;
      end
   end

   // DMEM returns read data one cycle after the address, so a granted DMA read answers next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rsp_pending_r <= 1'b0;
         rsp_hold_r    <= {DMEM_WORD_WIDTH{1'b0}};
      end else begin
         rsp_pending_r <= grant_s & ~dma_req_we;
         if (rsp_pending_r) begin
            rsp_hold_r <= dmem_rd_word;
         end else begin
            rsp_hold_r <= rsp_hold_r;
         end
      end
   end

   assign dma_rsp_valid = rsp_pending_r;
   assign dma_rsp_data  = rsp_pending_r ? dmem_rd_word : rsp_hold_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic, checked against a
// rule-level reference model and a response scoreboard. Honours DMEM_ARB_FAIRNESS_EN.
module tb_dmem_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 16;
   localparam int LIMIT = 8;
   localparam int CW = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clock, reset;
   logic cpu_rd_en, cpu_wr_en, cpu_stall;
   logic [AW-1:0] cpu_rd_addr, cpu_wr_addr;
   logic [DW-1:0] cpu_wr_word;
   logic dma_req_valid, dma_req_ready, dma_req_we, dma_rsp_valid;
   logic [AW-1:0] dma_req_addr;
   logic [DW-1:0] dma_req_wdata, dma_rsp_data;
   logic [AW-1:0] dmem_rd_addr, dmem_wr_addr;
   logic [DW-1:0] dmem_wr_word, dmem_rd_word;
   logic dmem_write_en;

   dmem_port_arbiter #(
      .DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(DW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset(reset),
      .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
      .cpu_rd_addr(cpu_rd_addr), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_word(cpu_wr_word),
      .cpu_stall(cpu_stall),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
      .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
      .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
      .dmem_rd_addr(dmem_rd_addr), .dmem_wr_addr(dmem_wr_addr), .dmem_wr_word(dmem_wr_word),
      .dmem_write_en(dmem_write_en), .dmem_rd_word(dmem_rd_word)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   function automatic logic [DW-1:0] init_val(int a);
      logic [DW-1:0] v;
      if (a < 4) v = 16'h00A0 + DW'(a);
      else       v = DW'(a * 291) ^ 16'h5A5A;
      return v;
   endfunction

   // Attached synchronous-read memory, preloaded on the first edge.
   logic [DW-1:0] mem [0:4095];
   bit preloaded = 1'b0;
   always @(posedge clock) begin
      if (!preloaded) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
         preloaded <= 1'b1;
         dmem_rd_word <= 16'h0000;
      end else begin
         if (dmem_write_en) mem[dmem_wr_addr] <= dmem_wr_word;
         dmem_rd_word <= mem[dmem_rd_addr];
      end
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // Reference model state: memory contents as seen by the spec, starvation count, responses.
   logic [DW-1:0] ref_mem [int];
   typedef struct { logic [DW-1:0] data; int cyc; } rsp_t;
   rsp_t q[$];
   int exp_cnt = 0;
   logic [DW-1:0] exp_hold = 16'h0000;
   bit exp_ready_l = 1'b0;
   bit exp_stall_l = 1'b0;

   function automatic logic [DW-1:0] ref_rd(int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   always @(posedge reset) begin
      q.delete();
      exp_hold = 16'h0000;
      exp_cnt = 0;
   end

   bit m_act, m_frc, m_ready, m_stall, m_we;
   logic [AW-1:0] m_ra, m_wa;
   logic [DW-1:0] m_wd;
   always @(negedge clock) begin
      if (!reset) begin
         m_act   = cpu_rd_en || cpu_wr_en;
         m_frc   = FAIR && (exp_cnt == LIMIT) && dma_req_valid;
         m_ready = dma_req_valid && (!m_act || m_frc);
         m_stall = m_frc && m_act;
         if (m_ready) begin
            m_ra = dma_req_addr; m_wa = dma_req_addr; m_wd = dma_req_wdata; m_we = dma_req_we;
         end else begin
            m_ra = cpu_rd_addr; m_wa = cpu_wr_addr; m_wd = cpu_wr_word; m_we = cpu_wr_en && !m_stall;
         end
         chk("ready", dma_req_ready, m_ready);
         chk("stall", cpu_stall, m_stall);
         chk("write_en", dmem_write_en, m_we);
         chk("rd_addr", dmem_rd_addr, m_ra);
         chk("wr_addr", dmem_wr_addr, m_wa);
         chk("wr_word", dmem_wr_word, m_wd);
         if (m_ready && !dma_req_we) q.push_back('{data: ref_rd(int'(dma_req_addr)), cyc: cyc + 1});
         if (m_we) ref_mem[int'(m_wa)] = m_wd;
         if (m_ready) exp_cnt = 0;
         else if (dma_req_valid && m_act) exp_cnt = (exp_cnt < LIMIT) ? exp_cnt + 1 : LIMIT;
         else if (!dma_req_valid) exp_cnt = 0;
         exp_ready_l = m_ready;
         exp_stall_l = m_stall;
      end
   end

   // Response monitor: pops one expected read per valid pulse, otherwise checks the held word.
   rsp_t e;
   always @(negedge clock) begin
      if (!reset) begin
         if (dma_rsp_valid) begin
            if (q.size() == 0) begin
               chk("rsp_spurious", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("rsp_data", dma_rsp_data, e.data);
               chk("rsp_cycle", cyc, e.cyc);
               exp_hold = e.data;
            end
         end else begin
            chk("rsp_hold", dma_rsp_data, exp_hold);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
               chk("rsp_missing", 32'd0, 32'd1);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
      cpu_rd_addr = 12'h000; cpu_wr_addr = 12'h000; cpu_wr_word = 16'h0000;
      dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = 12'h000; dma_req_wdata = 16'h0000;
      repeat (3) @(posedge clock);
      #2;
      chk("reset_rsp_valid", dma_rsp_valid, 32'd0);
      chk("reset_rsp_data", dma_rsp_data, 32'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      tick();

      // DMA write then read-back with CPU idle
      dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 12'h010; dma_req_wdata = 16'hBEEF;
      tick();
      dma_req_we = 1'b0;
      tick();
      dma_req_valid = 1'b0;
      repeat (3) tick();

      // CPU store wins over a waiting DMA read
      dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 12'h030;
      cpu_wr_en = 1'b1; cpu_wr_addr = 12'h020; cpu_wr_word = 16'h1234;
      tick();
      cpu_wr_en = 1'b0;
      tick();
      dma_req_valid = 1'b0;
      repeat (2) tick();

      // Back-to-back reads of the preloaded words
      dma_req_valid = 1'b1; dma_req_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dma_req_addr = AW'(i);
         tick();
      end
      dma_req_valid = 1'b0;
      repeat (3) tick();

      // CPU busy every cycle with DMA waiting: forced grant only in the fairness build
      dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 12'h005;
      cpu_wr_en = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!exp_stall_l) begin
            cpu_wr_addr = AW'($urandom_range(0, 63));
            cpu_wr_word = DW'($urandom);
         end
         if (exp_ready_l) dma_req_addr = AW'($urandom_range(0, 63));
         tick();
      end
      dma_req_valid = 1'b0; cpu_wr_en = 1'b0;
      repeat (2) tick();

      // Reset in the cycle after a DMA read grant drops the response immediately
      dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 12'h002;
      @(posedge clock);
      dma_req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("reset_mid_rsp_valid", dma_rsp_valid, 32'd0);
      chk("reset_mid_rsp_data", dma_rsp_data, 32'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      exp_ready_l = 1'b0; exp_stall_l = 1'b0;
      tick();

      // Random traffic with the DMA stability rule and stalled CPU accesses held
      for (int i = 0; i < 600; i++) begin
         if (!(dma_req_valid && !exp_ready_l)) begin
            dma_req_valid = ($urandom_range(0, 9) < 6);
            dma_req_we    = $urandom_range(0, 1) == 1;
            dma_req_addr  = AW'($urandom_range(0, 63));
            dma_req_wdata = DW'($urandom);
         end
         if (!exp_stall_l) begin
            cpu_rd_en   = $urandom_range(0, 1) == 1;
            cpu_wr_en   = ($urandom_range(0, 9) < 3);
            cpu_rd_addr = AW'($urandom_range(0, 63));
            cpu_wr_addr = AW'($urandom_range(0, 63));
            cpu_wr_word = DW'($urandom);
         end
         tick();
      end
      dma_req_valid = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
      repeat (4) tick();
      chk("rsp_queue_empty", q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
